maze_path_serializer: RTL and testbench

- Downstream consumer of the maze wall-follower solver.
- When the solver raises done, the block snapshots the solver's SIZE x SIZE visited-path bitmap.
- It scans the snapshot row-major (y outer, x inner) and streams the coordinate of every set cell over a valid/ready interface, then reports the total cell count.
- Once the snapshot is taken, the solver may be reset without disturbing the transfer.

---
 rtl/maze_path_serializer.sv | 188 ++++++++++++++++++
 tb/tb_maze_path_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_serializer.sv
// Snapshots the solver's visited bitmap on a start edge and streams every set cell
// row-major over valid/ready. Optional macro MAZE_PATH_SERIALIZER_STALL_CNT_EN adds stall_cycles.
module maze_path_serializer #(
  parameter int SIZE = 9,
  parameter int N    = 4,
  parameter int CW   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SIZE-1:0]     path [SIZE-1:0],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_x,
  output logic [N-1:0]        out_y,
  output logic                out_last,
  output logic                busy,
  output logic                finished,
  output logic [CW-1:0]       cell_count
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam int CELLS = SIZE * SIZE;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              start_d_reg;
  logic [CELLS-1:0]  snap_reg, snap_next;
  logic [CELLS-1:0]  path_flat;
  logic [CELLS-1:0]  cur_mask;
  logic [N-1:0]      sx_reg, sx_next, sy_reg, sy_next;
  logic [N-1:0]      sx_adv, sy_adv;
  logic [IW-1:0]     idx_reg, idx_next;
  logic              valid_reg, valid_next, last_reg, last_next;
  logic [N-1:0]      x_reg, x_next, y_reg, y_next;
  logic              busy_reg, busy_next, fin_reg, fin_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              start_edge, cur_set, others_set, at_end, handshake;

  // Flatten the bitmap so bit y*SIZE+x tracks the row-major scan index.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_flat
      assign path_flat[gi*SIZE +: SIZE] = path[gi];
    end
  endgenerate

  assign start_edge = start && !start_d_reg;
  assign cur_mask   = {{(CELLS-1){1'b0}}, 1'b1} << idx_reg;
  assign cur_set    = |(snap_reg & cur_mask);
  assign others_set = |(snap_reg & ~cur_mask);
  assign at_end     = (idx_reg == IW'(CELLS-1));
  assign handshake  = valid_reg && out_ready;
  assign sx_adv     = (sx_reg == N'(SIZE-1)) ? '0 : sx_reg + N'(1);
  assign sy_adv     = (sx_reg == N'(SIZE-1)) ? sy_reg + N'(1) : sy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      start_d_reg <= 1'b0;
      snap_reg    <= '0;
      sx_reg      <= '0;
      sy_reg      <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      busy_reg    <= 1'b0;
      fin_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      start_d_reg <= start;
      snap_reg    <= snap_next;
      sx_reg      <= sx_next;
      sy_reg      <= sy_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      last_reg    <= last_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      busy_reg    <= busy_next;
      fin_reg     <= fin_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    sx_next    = sx_reg;
    sy_next    = sy_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    busy_next  = busy_reg;
    fin_next   = 1'b0;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next = SCAN;
          snap_next  = path_flat;
          sx_next    = '0;
          sy_next    = '0;
          idx_next   = '0;
          count_next = '0;
          busy_next  = 1'b1;
        end
      end
      SCAN: begin
        if (cur_set) begin
          state_next = EMIT;
          valid_next = 1'b1;
          x_next     = sx_reg;
          y_next     = sy_reg;
          last_next  = !others_set;
        end else if (at_end) begin
          state_next = DONE;
        end else begin
          sx_next  = sx_adv;
          sy_next  = sy_adv;
          idx_next = idx_reg + IW'(1);
        end
      end
      EMIT: begin
        if (handshake) begin
          snap_next  = snap_reg & ~cur_mask;
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (count_reg != {CW{1'b1}}) count_next = count_reg + CW'(1);
          if (last_reg) begin
            state_next = DONE;
          end else begin
            // The wrap cannot overrun: a non-last beat always has a later set cell.
            state_next = SCAN;
            sx_next    = sx_adv;
            sy_next    = sy_adv;
            idx_next   = idx_reg + IW'(1);
          end
        end
      end
      DONE: begin
        fin_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid  = valid_reg;
  assign out_x      = x_reg;
  assign out_y      = y_reg;
  assign out_last   = last_reg;
  assign busy       = busy_reg;
  assign finished   = fin_reg;
  assign cell_count = count_reg;

`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
  logic [15:0] stall_reg, stall_next;

  always_comb begin
    stall_next = stall_reg;
    if (state_reg == IDLE && start_edge) begin
      stall_next = '0;
    end else if (valid_reg && !out_ready && stall_reg != 16'hFFFF) begin
      stall_next = stall_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_reg <= '0;
    else        stall_reg <= stall_next;
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_maze_path_serializer.sv
// Randomized self-checking bench for maze_path_serializer; expected beats and edge timing
// come from a row-major reference model driven by a pre-generated out_ready pattern.
`timescale 1ns/1ps
module tb_maze_path_serializer;
  localparam int SIZE  = 9;
  localparam int N     = 4;
  localparam int CW    = 7;
  localparam int CELLS = SIZE * SIZE;
  localparam int MAXC  = 1023;

  logic            clk = 1'b0;
  logic            rst_n, start, out_ready;
  logic [SIZE-1:0] path [SIZE-1:0];
  logic            out_valid, out_last, busy, finished;
  logic [N-1:0]    out_x, out_y;
  logic [CW-1:0]   cell_count;
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
  logic [15:0]     stall_cycles;
`endif

  maze_path_serializer #(.SIZE(SIZE), .N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .path(path),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .busy(busy), .finished(finished), .cell_count(cell_count)
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  bit              ready_pat [0:MAXC];
  logic [SIZE-1:0] ref_map [SIZE-1:0];
  int exp_x[$], exp_y[$], exp_hs[$];
  int exp_first, exp_fin, exp_stall;
  int mon_x[$], mon_y[$], mon_last[$], mon_hs[$];
  int mon_first, mon_fin, mon_fin_cnt, mon_viol;

  task automatic fill_ready(input int prob);
    for (int e = 0; e <= MAXC; e++) ready_pat[e] = ($urandom_range(99) < prob);
  endtask

  task automatic prep();
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int y = 0; y < SIZE; y++) path[y] = '0;
  endtask

  // Edge 1 is the clock that samples the start edge; a set cell k is examined on edge k+2,
  // or on edge h+(k-k_prev) after the previous beat's handshake edge h.
  task automatic model();
    int prev_k, v, h, k;
    exp_x.delete(); exp_y.delete(); exp_hs.delete();
    exp_stall = 0; exp_first = -1; h = -1; prev_k = 0;
    for (int y = 0; y < SIZE; y++) begin
      for (int x = 0; x < SIZE; x++) begin
        if (ref_map[y][x]) begin
          k = y * SIZE + x;
          v = (h < 0) ? k + 2 : h + (k - prev_k);
          if (exp_first < 0) exp_first = v;
          h = v + 1;
          while (h < MAXC && !ready_pat[h]) h++;
          exp_stall += h - v - 1;
          exp_x.push_back(x); exp_y.push_back(y); exp_hs.push_back(h);
          prev_k = k;
        end
      end
    end
    exp_fin = (h < 0) ? CELLS + 2 : h + 1;
  endtask

  // Drives start and the ready pattern edge by edge and records what the DUT produced.
  task automatic run_xfer(input int max_edges, input bit disturb);
    logic [N-1:0] px, py;
    logic         pl, pv, hs;
    mon_x.delete(); mon_y.delete(); mon_last.delete(); mon_hs.delete();
    mon_first = -1; mon_fin = -1; mon_fin_cnt = 0; mon_viol = 0;
    start = 1'b1;
    for (int n = 1; n <= max_edges; n++) begin
      out_ready = ready_pat[n];
      hs = out_valid && out_ready;
      if (hs) begin
        mon_x.push_back(int'(out_x)); mon_y.push_back(int'(out_y));
        mon_last.push_back(int'(out_last)); mon_hs.push_back(n);
        $display("beat x=%0d y=%0d last=%0d edge=%0d", out_x, out_y, out_last, n);
      end
      if (disturb && out_valid && !out_last) begin
        start = ~start;
        for (int y = 0; y < SIZE; y++) path[y] = SIZE'($urandom);
      end
      px = out_x; py = out_y; pl = out_last; pv = out_valid;
      @(posedge clk);
      @(negedge clk);
      if (out_valid && mon_first < 0) mon_first = n;
      if (pv && !hs && (!out_valid || out_x !== px || out_y !== py || out_last !== pl)) mon_viol++;
      if (hs && out_valid) mon_viol++;
      if (finished) begin
        mon_fin_cnt++;
        if (mon_fin < 0) mon_fin = n;
      end
      if (mon_fin >= 0 && n >= mon_fin + 2) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int y = 0; y < SIZE; y++) path[y] = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (finished !== 1'b0) $display("FAIL reset_finished got %b want 0", finished); else passed++;
    checks++; if (cell_count !== '0) $display("FAIL reset_count got %0d want 0", cell_count); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else passed++;
    checks++; if (out_x !== '0 || out_y !== '0) $display("FAIL reset_xy got (%0d,%0d) want (0,0)", out_x, out_y); else passed++;
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
    checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall got %0d want 0", stall_cycles); else passed++;
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL idle_quiet got busy=%b valid=%b want 0,0", busy, out_valid); else passed++;
  endtask

  task automatic test_single_cell();
    prep();
    path[0][3] = 1'b1;
    fill_ready(100);
    run_xfer(20, 1'b0);
    checks++; if (mon_x.size() != 1) $display("FAIL single_beats got %0d want 1", mon_x.size()); else passed++;
    checks++;
    if (mon_x.size() < 1 || mon_x[0] != 3 || mon_y[0] != 0 || mon_last[0] != 1)
      $display("FAIL single_beat got (%0d,%0d,last%0d) want (3,0,last1)", mon_x.size() ? mon_x[0] : -1, mon_x.size() ? mon_y[0] : -1, mon_x.size() ? mon_last[0] : -1);
    else passed++;
    checks++; if (mon_first != 5) $display("FAIL single_latency got edge %0d want edge 5", mon_first); else passed++;
    checks++; if (mon_fin != 7 || mon_fin_cnt != 1) $display("FAIL single_finished got edge %0d x%0d want edge 7 x1", mon_fin, mon_fin_cnt); else passed++;
    checks++; if (cell_count !== 7'd1 || busy !== 1'b0) $display("FAIL single_count got %0d busy=%b want 1 busy=0", cell_count, busy); else passed++;
  endtask

  task automatic test_column();
    prep();
    for (int y = 0; y < SIZE; y++) path[y][4] = 1'b1;
    fill_ready(100);
    run_xfer(100, 1'b0);
    checks++; if (mon_x.size() != 9) $display("FAIL column_beats got %0d want 9", mon_x.size()); else passed++;
    for (int i = 0; i < 9 && i < mon_x.size(); i++) begin
      checks++;
      if (mon_x[i] != 4 || mon_y[i] != i || mon_last[i] != int'(i == 8))
        $display("FAIL column_beat%0d got (%0d,%0d,last%0d) want (4,%0d,last%0d)", i, mon_x[i], mon_y[i], mon_last[i], i, int'(i == 8));
      else passed++;
    end
    checks++; if (mon_fin != 88 || mon_fin_cnt != 1) $display("FAIL column_finished got edge %0d x%0d want edge 88 x1", mon_fin, mon_fin_cnt); else passed++;
    checks++; if (cell_count !== 7'd9) $display("FAIL column_count got %0d want 9", cell_count); else passed++;
  endtask

  task automatic test_backpressure();
    prep();
    path[0][1] = 1'b1;
    path[0][2] = 1'b1;
    fill_ready(100);
    for (int e = 4; e <= 8; e++) ready_pat[e] = 1'b0;
    run_xfer(40, 1'b0);
    checks++; if (mon_first != 3) $display("FAIL bp_first_valid got edge %0d want edge 3", mon_first); else passed++;
    checks++; if (mon_viol != 0) $display("FAIL bp_stable got %0d violations want 0", mon_viol); else passed++;
    checks++;
    if (mon_x.size() != 2 || mon_x[0] != 1 || mon_y[0] != 0 || mon_last[0] != 0 || mon_hs[0] != 9 ||
        mon_x[1] != 2 || mon_y[1] != 0 || mon_last[1] != 1)
      $display("FAIL bp_beats got %0d beats want (1,0,last0,@9),(2,0,last1)", mon_x.size());
    else passed++;
    checks++; if (mon_fin != 12) $display("FAIL bp_finished got edge %0d want edge 12", mon_fin); else passed++;
    checks++; if (cell_count !== 7'd2) $display("FAIL bp_count got %0d want 2", cell_count); else passed++;
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
    checks++; if (stall_cycles !== 16'd5) $display("FAIL bp_stall got %0d want 5", stall_cycles); else passed++;
`endif
  endtask

  task automatic test_empty();
    prep();
    fill_ready(50);
    run_xfer(100, 1'b0);
    checks++; if (mon_x.size() != 0 || mon_first != -1) $display("FAIL empty_beats got %0d beats first=%0d want 0 beats", mon_x.size(), mon_first); else passed++;
    checks++; if (mon_fin != CELLS + 2 || mon_fin_cnt != 1) $display("FAIL empty_finished got edge %0d x%0d want edge %0d x1", mon_fin, mon_fin_cnt, CELLS + 2); else passed++;
    checks++; if (cell_count !== 7'd0 || busy !== 1'b0) $display("FAIL empty_count got %0d busy=%b want 0 busy=0", cell_count, busy); else passed++;
  endtask

  task automatic test_start_while_busy();
    prep();
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++) path[y][x] = ($urandom_range(2) == 0);
    path[0][0] = 1'b1;
    path[8][8] = 1'b1;
    ref_map = path;
    fill_ready(50);
    model();
    run_xfer((exp_fin + 4 > MAXC) ? MAXC : exp_fin + 4, 1'b1);
    checks++; if (mon_x.size() != exp_x.size()) $display("FAIL busy_beats got %0d want %0d", mon_x.size(), exp_x.size()); else passed++;
    for (int i = 0; i < exp_x.size() && i < mon_x.size(); i++) begin
      checks++;
      if (mon_x[i] != exp_x[i] || mon_y[i] != exp_y[i] || mon_hs[i] != exp_hs[i] || mon_last[i] != int'(i == exp_x.size() - 1))
        $display("FAIL busy_beat%0d got (%0d,%0d,last%0d,@%0d) want (%0d,%0d,@%0d)", i, mon_x[i], mon_y[i], mon_last[i], mon_hs[i], exp_x[i], exp_y[i], exp_hs[i]);
      else passed++;
    end
    checks++; if (mon_fin != exp_fin || mon_fin_cnt != 1) $display("FAIL busy_finished got edge %0d x%0d want edge %0d x1", mon_fin, mon_fin_cnt, exp_fin); else passed++;
    checks++; if (cell_count !== CW'(exp_x.size())) $display("FAIL busy_count got %0d want %0d", cell_count, exp_x.size()); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      prep();
      for (int y = 0; y < SIZE; y++)
        for (int x = 0; x < SIZE; x++) path[y][x] = ($urandom_range(3) == 0);
      ref_map = path;
      fill_ready(70);
      model();
      $display("transfer %0d expect beats=%0d stalls=%0d finish_edge=%0d", it, exp_x.size(), exp_stall, exp_fin);
      run_xfer((exp_fin + 4 > MAXC) ? MAXC : exp_fin + 4, 1'b0);
      checks++; if (mon_x.size() != exp_x.size()) $display("FAIL rand_beats got %0d want %0d", mon_x.size(), exp_x.size()); else passed++;
      for (int i = 0; i < exp_x.size() && i < mon_x.size(); i++) begin
        checks++;
        if (mon_x[i] != exp_x[i] || mon_y[i] != exp_y[i] || mon_hs[i] != exp_hs[i] || mon_last[i] != int'(i == exp_x.size() - 1))
          $display("FAIL rand_beat%0d got (%0d,%0d,last%0d,@%0d) want (%0d,%0d,@%0d)", i, mon_x[i], mon_y[i], mon_last[i], mon_hs[i], exp_x[i], exp_y[i], exp_hs[i]);
        else passed++;
      end
      checks++; if (mon_first != exp_first) $display("FAIL rand_first_valid got edge %0d want edge %0d", mon_first, exp_first); else passed++;
      checks++; if (mon_fin != exp_fin || mon_fin_cnt != 1) $display("FAIL rand_finished got edge %0d x%0d want edge %0d x1", mon_fin, mon_fin_cnt, exp_fin); else passed++;
      checks++; if (mon_viol != 0) $display("FAIL rand_protocol got %0d violations want 0", mon_viol); else passed++;
      checks++; if (cell_count !== CW'(exp_x.size()) || busy !== 1'b0) $display("FAIL rand_count got %0d busy=%b want %0d busy=0", cell_count, busy, exp_x.size()); else passed++;
`ifdef MAZE_PATH_SERIALIZER_STALL_CNT_EN
      checks++; if (stall_cycles !== 16'(exp_stall)) $display("FAIL rand_stall got %0d want %0d", stall_cycles, exp_stall); else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    prep();
    for (int y = 0; y < SIZE; y++) path[y] = '1;
    out_ready = 1'b1;
    start = 1'b1;
    guard = 0;
    while (!(out_valid && cell_count >= 7'd2) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    checks++; if (guard >= 100) $display("FAIL rmid_reach got timeout want beat in EMIT"); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) $display("FAIL rmid_valid got valid=%b last=%b want 0,0", out_valid, out_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    checks++; if (cell_count !== '0) $display("FAIL rmid_count got %0d want 0", cell_count); else passed++;
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++) path[y][x] = ($urandom_range(4) == 0);
    path[2][5] = 1'b1;
    @(negedge clk);
    checks++; if (finished !== 1'b0) $display("FAIL rmid_no_finish got %b want 0", finished); else passed++;
    @(negedge clk);
    ref_map = path;
    fill_ready(80);
    model();
    rst_n = 1'b1;
    run_xfer((exp_fin + 4 > MAXC) ? MAXC : exp_fin + 4, 1'b0);
    checks++; if (mon_x.size() != exp_x.size()) $display("FAIL rmid_beats got %0d want %0d", mon_x.size(), exp_x.size()); else passed++;
    for (int i = 0; i < exp_x.size() && i < mon_x.size(); i++) begin
      checks++;
      if (mon_x[i] != exp_x[i] || mon_y[i] != exp_y[i] || mon_hs[i] != exp_hs[i] || mon_last[i] != int'(i == exp_x.size() - 1))
        $display("FAIL rmid_beat%0d got (%0d,%0d,last%0d,@%0d) want (%0d,%0d,@%0d)", i, mon_x[i], mon_y[i], mon_last[i], mon_hs[i], exp_x[i], exp_y[i], exp_hs[i]);
      else passed++;
    end
    checks++; if (mon_fin != exp_fin || mon_fin_cnt != 1) $display("FAIL rmid_finished got edge %0d x%0d want edge %0d x1", mon_fin, mon_fin_cnt, exp_fin); else passed++;
    checks++; if (cell_count !== CW'(exp_x.size())) $display("FAIL rmid_count got %0d want %0d", cell_count, exp_x.size()); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_cell();
    test_column();
    test_backpressure();
    test_empty();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
